fp_operand_unpack: RTL
======================

FP_OPERAND_UNPACK -- requirements
Module: fp_operand_unpack

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, giving the width of the denormal-flush statistics counter.
REQ-002 SHALL have exactly one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  operand pair valid.
REQ-006 in_ready  out  1  stage can accept a pair.
REQ-007 in_a, in_b  in  32 each  packed IEEE-754 binary32 operands.
REQ-008 out_valid  out  1  unpacked pair valid.
REQ-009 out_ready  in  1  downstream multiplier stage accepts.
REQ-010 out_sign_x, out_sign_y  out  1 each  operand signs.
REQ-011 out_exp_x, out_exp_y  out  8 each  biased exponents.
REQ-012 out_mantissa_x, out_mantissa_y  out  23 each  fraction fields, hidden bit excluded.
REQ-013 out_special  out  1  result is fully determined here; downstream uses out_special_result and ignores the multiplier.
REQ-014 out_special_result  out  32  packed bypass result, valid when out_special=1.
REQ-015 denorm_flush_cnt  out  CNT_WIDTH  saturating count of flushed denormal operands.

Function
REQ-016 A beat SHALL transfer on the input when in_valid&&in_ready, and on the output when out_valid&&out_ready.
REQ-017 Latency SHALL be 1 cycle from input acceptance to out_valid when the stage is empty; throughput 1 pair/cycle while out_ready=1.
REQ-018 Storage SHALL be a main output register plus one skid register; in_ready SHALL be a registered signal equal to "skid register empty".
REQ-019 Beats SHALL leave in acceptance order with no loss or duplication under any out_ready pattern.
REQ-020 While out_valid=1 and out_ready=0, all out_* fields SHALL hold stable.
REQ-021 Classification per operand: exp=255 and mant!=0 is NAN; exp=255 and mant=0 is INF; exp=0 (mant any) is ZERO; otherwise NORMAL.
REQ-022 An operand with exp=0 and mant!=0 SHALL be flushed to ZERO.
REQ-023 Special-result priority SHALL be: either NAN -> 0x7FC00000; INF with ZERO -> 0x7FC00000; either INF -> {sx^sy, 0x7F800000[30:0]}; either ZERO -> {sx^sy, 31'b0}; otherwise out_special=0.
REQ-024 Field outputs SHALL carry the raw input fields regardless of out_special; flushed operands SHALL present mantissa 0.
REQ-025 denorm_flush_cnt SHALL increase by the number of flushed operands (0, 1 or 2) per accepted beat only, and SHALL saturate at all-ones without wrapping.

Reset
REQ-026 While rst=1 at a clock edge: out_valid=0, in_ready=1, skid register empty, denorm_flush_cnt=0, and all out_* data fields=0; rst SHALL take priority over a simultaneous handshake.
REQ-027 A beat held at reset assertion SHALL be discarded; the first post-reset beat SHALL behave as if the stage was empty.

Structure
REQ-028 Package fp_mul_pkg SHALL hold the FP32 width constants (EXP_W=8, MANT_W=23, EXP_BIAS=127), QNAN=0x7FC00000, INF_MAG=0x7F800000, and the class enum {ZERO, NORMAL, INF, NAN}.
REQ-029 The combinational sub-module fp32_classify (one 32-bit word in; class, sign, exp, flushed mantissa and denormal flag out) SHALL be instantiated twice.

Verification
REQ-030 in_a=0x3FC00000, in_b=0x40000000, out_ready=1 -> next cycle out_valid=1, signs 0/0, exps 0x7F/0x80, mantissas 0x400000/0x000000, out_special=0.
REQ-031 in_a=0x7FC00001, in_b=0x3F800000 -> out_special=1, result 0x7FC00000; in_a=0xFF800000, in_b=0x00000000 -> 0x7FC00000; in_a=0xFF800000, in_b=0xC0000000 -> 0x7F800000.
REQ-032 in_a=0x00000001, in_b=0x80400000 -> out_special=1, result 0x80000000, denorm_flush_cnt +2; 70000 such beats -> counter holds 0xFFFF.
REQ-033 out_ready=0 while three beats are offered -> in_ready falls after two accepts; on out_ready=1, beats emerge in order with the third accepted then, and none lost.
REQ-034 rst pulsed while out_valid=1 and the skid register is full -> next cycle out_valid=0, in_ready=1, counter=0; the next beat emerges after 1 cycle.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared FP32 constants, operand classes and the unpacked-pair payload
// carried by the multiplier front end.
package fp_mul_pkg;

    localparam int unsigned FP_W     = 32;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MANT_W   = 23;
    localparam int unsigned EXP_BIAS = 127;

    localparam logic [FP_W-1:0] QNAN    = 32'h7FC0_0000;
    localparam logic [FP_W-1:0] INF_MAG = 32'h7F80_0000;

    typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_e;

    typedef struct packed {
        logic              sign_x;
        logic              sign_y;
        logic [EXP_W-1:0]  exp_x;
        logic [EXP_W-1:0]  exp_y;
        logic [MANT_W-1:0] mant_x;
        logic [MANT_W-1:0] mant_y;
        logic              special;
        logic [FP_W-1:0]   special_result;
    } payload_t;

endpackage

// File: rtl/fp_operand_unpack_if.sv
// Operand-pair input handshake and unpacked-pair output handshake.
interface fp_operand_unpack_if;
    import fp_mul_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [FP_W-1:0]   in_a;
    logic [FP_W-1:0]   in_b;
    logic              out_valid;
    logic              out_ready;
    logic              out_sign_x;
    logic              out_sign_y;
    logic [EXP_W-1:0]  out_exp_x;
    logic [EXP_W-1:0]  out_exp_y;
    logic [MANT_W-1:0] out_mantissa_x;
    logic [MANT_W-1:0] out_mantissa_y;
    logic              out_special;
    logic [FP_W-1:0]   out_special_result;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sign_x, out_sign_y, out_exp_x, out_exp_y,
               out_mantissa_x, out_mantissa_y, out_special, out_special_result
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sign_x, out_sign_y, out_exp_x, out_exp_y,
               out_mantissa_x, out_mantissa_y, out_special, out_special_result
    );

endinterface

// File: rtl/fp32_classify.sv
// Splits one binary32 word into fields and classifies it; denormals flush to ZERO.
module fp32_classify
    import fp_mul_pkg::*;
(
    input  logic [FP_W-1:0]   word_i,
    output fp_class_e         class_o,
    output logic              sign_o,
    output logic [EXP_W-1:0]  exp_o,
    output logic [MANT_W-1:0] mant_o,
    output logic              denorm_o
);

    logic [MANT_W-1:0] raw_mant;

    always_comb begin
        sign_o   = word_i[FP_W-1];
        exp_o    = word_i[FP_W-2:MANT_W];
        raw_mant = word_i[MANT_W-1:0];
        denorm_o = (exp_o == '0) && (raw_mant != '0);
        mant_o   = denorm_o ? '0 : raw_mant;

        if (exp_o == '1) begin
            class_o = (raw_mant != '0) ? NAN : INF;
        end else if (exp_o == '0) begin
            class_o = ZERO;
        end else begin
            class_o = NORMAL;
        end
    end

endmodule

// File: rtl/fp_operand_unpack.sv
// Operand unpack stage: classifies both operands, resolves bypass results and
// buffers the pair in a main register plus one skid register.
module fp_operand_unpack
    import fp_mul_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fp_operand_unpack_if.slave   bus,
    output logic [CNT_WIDTH-1:0] denorm_flush_cnt
);

    fp_class_e         class_x, class_y;
    logic              sign_x, sign_y, denorm_x, denorm_y;
    logic [EXP_W-1:0]  exp_x, exp_y;
    logic [MANT_W-1:0] mant_x, mant_y;

    fp32_classify u_class_x (
        .word_i   (bus.in_a),
        .class_o  (class_x),
        .sign_o   (sign_x),
        .exp_o    (exp_x),
        .mant_o   (mant_x),
        .denorm_o (denorm_x)
    );

    fp32_classify u_class_y (
        .word_i   (bus.in_b),
        .class_o  (class_y),
        .sign_o   (sign_y),
        .exp_o    (exp_y),
        .mant_o   (mant_y),
        .denorm_o (denorm_y)
    );

    payload_t in_payload;
    logic     sign_r;

    always_comb begin
        sign_r                    = sign_x ^ sign_y;
        in_payload                = '0;
        in_payload.sign_x         = sign_x;
        in_payload.sign_y         = sign_y;
        in_payload.exp_x          = exp_x;
        in_payload.exp_y          = exp_y;
        in_payload.mant_x         = mant_x;
        in_payload.mant_y         = mant_y;
        if (class_x == NAN || class_y == NAN) begin
            in_payload.special        = 1'b1;
            in_payload.special_result = QNAN;
        end else if ((class_x == INF && class_y == ZERO) || (class_x == ZERO && class_y == INF)) begin
            in_payload.special        = 1'b1;
            in_payload.special_result = QNAN;
        end else if (class_x == INF || class_y == INF) begin
            in_payload.special        = 1'b1;
            in_payload.special_result = {sign_r, INF_MAG[FP_W-2:0]};
        end else if (class_x == ZERO || class_y == ZERO) begin
            in_payload.special        = 1'b1;
            in_payload.special_result = {sign_r, {(FP_W-1){1'b0}}};
        end
    end

    logic                 main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    payload_t             main_q, main_d, skid_q, skid_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH:0]   cnt_sum;
    logic [1:0]           flush_num;
    logic                 in_fire, out_fire;

    always_comb begin
        in_fire      = bus.in_valid && !skid_valid_q;
        out_fire     = main_valid_q && bus.out_ready;
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;

        // Main register frees up: refill from skid first to keep order.
        if (!main_valid_q || out_fire) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_valid_d = 1'b1;
                main_d       = in_payload;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_d       = in_payload;
        end

        flush_num = {1'b0, denorm_x} + {1'b0, denorm_y};
        cnt_sum   = {1'b0, cnt_q} + (CNT_WIDTH+1)'(flush_num);
        cnt_d     = cnt_q;
        if (in_fire) begin
            cnt_d = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
            cnt_q        <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.in_ready           = ~skid_valid_q;
    assign bus.out_valid          = main_valid_q;
    assign bus.out_sign_x         = main_q.sign_x;
    assign bus.out_sign_y         = main_q.sign_y;
    assign bus.out_exp_x          = main_q.exp_x;
    assign bus.out_exp_y          = main_q.exp_y;
    assign bus.out_mantissa_x     = main_q.mant_x;
    assign bus.out_mantissa_y     = main_q.mant_y;
    assign bus.out_special        = main_q.special;
    assign bus.out_special_result = main_q.special_result;
    assign denorm_flush_cnt       = cnt_q;

endmodule
